weight_fetch: RTL

WEIGHT_FETCH -- requirements
Module: weight_fetch

---
 rtl/weight_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/weight_fetch.sv
// Weight fetch engine: reads a job of 64-bit beats as 4 KB-safe AXI read bursts and
// streams them out through a first-word fall-through buffer with per-entry TLAST.
module weight_fetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ACP_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [11:0]           num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [3:0]            M_AXI_ARLEN,
  input  logic                  M_AXI_RVALID,
  input  logic                  M_AXI_RLAST,
  input  logic [ACP_WIDTH-1:0]  M_AXI_RDATA,
  output logic                  M_AXI_RREADY,
  output logic [ACP_WIDTH-1:0]  M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           rem_q, rem_d;
  logic [4:0]            len_q, len_d;
  logic [4:0]            beat_q, beat_d;
  logic                  done_q, done_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic [ACP_WIDTH:0]    fifo_mem [FIFO_DEPTH];
  logic [ACP_WIDTH:0]    head;

  logic [9:0]            to_bnd;
  logic [4:0]            burst_len;
  logic [CntW-1:0]       free;
  logic                  push, pop, last_beat, push_last;

  // Beats left before the next 4 KB boundary (1..512).
  always_comb begin
    to_bnd    = 10'd512 - {1'b0, addr_q[11:3]};
    burst_len = 5'd16;
    if (rem_q < 12'd16) burst_len = rem_q[4:0];
    if (to_bnd < {5'd0, burst_len}) burst_len = to_bnd[4:0];
  end

  assign free          = CntW'(FIFO_DEPTH) - count_q;
  assign M_AXI_ARVALID = (state_q == StAddr) && (free >= CntW'(burst_len));
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 4'(burst_len - 5'd1);
  assign M_AXI_RREADY  = (state_q == StData);

  assign push      = (state_q == StData) && M_AXI_RVALID;
  assign last_beat = (beat_q == len_q - 5'd1);
  assign push_last = last_beat && (rem_q == 12'd0);
  assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;

  assign head          = fifo_mem[rd_ptr_q];
  assign M_AXIS_TVALID = (count_q != '0);
  assign M_AXIS_TDATA  = head[ACP_WIDTH-1:0];
  assign M_AXIS_TLAST  = M_AXIS_TVALID && head[ACP_WIDTH];

  assign busy = (state_q != StIdle);
  assign done = done_q;

  // Burst completion follows the internal beat counter, so RLAST is not needed.
  logic unused_in;
  assign unused_in = ^{M_AXI_RLAST, base_addr[2:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_beats == 12'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = {base_addr[ADDR_WIDTH-1:3], 3'b000};
            rem_d   = num_beats;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          addr_d  = addr_q + ADDR_WIDTH'({burst_len, 3'b000});
          rem_d   = rem_q - 12'(burst_len);
          len_d   = burst_len;
          beat_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (M_AXI_RVALID) begin
          beat_d = beat_q + 5'd1;
          if (last_beat) state_d = (rem_q != 12'd0) ? StAddr : StDrain;
        end
      end
      StDrain: begin
        if (count_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {push_last, M_AXI_RDATA};
  end

endmodule
